uart_tx_sched: RTL and testbench



---
 rtl/uart_tx_sched.sv | 131 +++++++++++++
 tb/tb_uart_tx_sched.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin UART transmit scheduler: four byte requesters share one 8N1 TX line.
// Define PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_tx_sched #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [31:0] data,
    output logic [3:0]  ack,
    output logic [1:0]  gnt_id,
    output logic        busy,
    output logic        tx
);
    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OW  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    if (DIV < 1) begin : g_bad_div
        $error("uart_tx_sched: CLK_FREQ too low for BAUD*OVERSAMPLE");
    end

`ifdef PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t        state;
    logic [DW-1:0] div_cnt;
    logic [OW-1:0] os_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    byte_q;
    logic [1:0]    last_winner;
    logic          win_found;
    logic [1:0]    win_id;
    logic          bit_end;

    // Later iterations overwrite earlier ones, so the requester closest
    // after last_winner wins; k=4 wraps back to last_winner itself.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 4; k >= 1; k--) begin
            if (req[last_winner + 2'(k)]) begin
                win_found = 1'b1;
                win_id    = last_winner + 2'(k);
            end
        end
    end

    assign bit_end = (div_cnt == DW'(DIV - 1)) && (os_cnt == OW'(OVERSAMPLE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            div_cnt     <= '0;
            os_cnt      <= '0;
            bit_idx     <= '0;
            byte_q      <= '0;
            last_winner <= 2'd3;
            ack         <= '0;
            gnt_id      <= '0;
            busy        <= 1'b0;
            tx          <= 1'b1;
        end else begin
            ack <= '0;
            if (state == S_IDLE) begin
                div_cnt <= '0;
                os_cnt  <= '0;
                if (win_found) begin
                    byte_q       <= data[8*win_id +: 8];
                    ack[win_id]  <= 1'b1;
                    gnt_id       <= win_id;
                    last_winner  <= win_id;
                    busy         <= 1'b1;
                    tx           <= 1'b0;
                    state        <= S_START;
                end
            end else begin
                if (div_cnt == DW'(DIV - 1)) begin
                    div_cnt <= '0;
                    os_cnt  <= (os_cnt == OW'(OVERSAMPLE - 1)) ? '0 : os_cnt + 1'b1;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
                if (bit_end) begin
                    case (state)
                        S_START: begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                            tx      <= byte_q[0];
                        end
                        S_DATA: begin
                            if (bit_idx == 3'd7) begin
`ifdef PARITY_EN
                                state <= S_PARITY;
                                tx    <= ^byte_q;
`else
                                state <= S_STOP;
                                tx    <= 1'b1;
`endif
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                                tx      <= byte_q[bit_idx + 3'd1];
                            end
                        end
`ifdef PARITY_EN
                        S_PARITY: begin
                            state <= S_STOP;
                            tx    <= 1'b1;
                        end
`endif
                        S_STOP: begin
                            // One idle cycle follows every frame before the next grant.
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                        default: begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            tx    <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: frame-level reference model plus directed scenarios.
// Build with PARITY_EN defined to exercise the 8E1 frame.
`timescale 1ns/1ps
module tb_uart_tx_sched;
    localparam int BIT = 64;
`ifdef PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] data = '0;
    logic [3:0]  ack;
    logic [1:0]  gnt_id;
    logic        busy;
    logic        tx;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc = 0;

    uart_tx_sched #(.CLK_FREQ(64), .BAUD(1), .OVERSAMPLE(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data(data),
        .ack(ack), .gnt_id(gnt_id), .busy(busy), .tx(tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a frame is a list of NB line levels, each held BIT clocks.
    logic        m_active;
    int          m_t;
    logic [10:0] m_frame;
    logic [3:0]  m_ack;
    logic [1:0]  m_id;
    int          m_last;
    int          m_w;
    logic [7:0]  m_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_t      = 0;
            m_frame  = '1;
            m_ack    = '0;
            m_id     = '0;
            m_last   = 3;
        end else begin
            m_ack = '0;
            if (m_active) begin
                m_t++;
                if (m_t == NB * BIT) m_active = 1'b0;
            end else if (req != 4'b0000) begin
                m_w = -1;
                for (int k = 1; k <= 4; k++)
                    if (m_w < 0 && req[(m_last + k) % 4]) m_w = (m_last + k) % 4;
                m_b = data[8*m_w +: 8];
`ifdef PARITY_EN
                m_frame = {1'b1, ^m_b, m_b, 1'b0};
`else
                m_frame = {2'b01, m_b, 1'b0};
`endif
                m_active   = 1'b1;
                m_t        = 0;
                m_ack[m_w] = 1'b1;
                m_id       = 2'(m_w);
                m_last     = m_w;
            end
        end
    end

    always @(negedge clk) begin
        check("tx", 32'(tx), 32'(m_active ? m_frame[4'(m_t / BIT)] : 1'b1));
        check("busy", 32'(busy), 32'(m_active));
        check("ack", 32'(ack), 32'(m_ack));
        check("gnt_id", 32'(gnt_id), 32'(m_id));
    end

    task automatic wait_ack(input string name, input logic [3:0] exp, input int limit);
        int n = 0;
        while (ack == 4'b0000 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(ack), 32'(exp));
    endtask

    // Called on the negedge right after the grant edge; samples mid-bit.
    task automatic capture(input logic [7:0] new_hi, input bit chg,
                           output logic [10:0] bits, output int blen);
        bits = '0;
        blen = 0;
        for (int t = 0; t < NB * BIT; t++) begin
            if (busy) blen++;
            if (t % BIT == BIT / 2) bits[t / BIT] = tx;
            if (chg && t == 1) data[15:8] = new_hi;
            @(negedge clk);
        end
        if (busy) blen++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [10:0] bits;
    int          blen;
    logic [1:0]  exp_q[$];
    int          prev_cyc;
    int          n_ack;

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_gnt", 32'(gnt_id), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single frame, byte A5 from requester 0.
        data = 32'h0000_00A5;
        req  = 4'b0001;
        wait_ack("t1_ack", 4'b0001, 4);
        req = 4'b0000;
        capture(8'h00, 1'b0, bits, blen);
`ifdef PARITY_EN
        check("t1_frame", 32'(bits), 32'h54A);
`else
        check("t1_frame", 32'(bits), 32'h34A);
`endif
        check("t1_busy_len", 32'(blen), 32'(NB * BIT));
        repeat (5) @(negedge clk);

        // All four requesting: fair order from reset, one-clock gaps.
        do_reset();
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        data = 32'h1312_1110;
        req  = 4'b1111;
        prev_cyc = -1;
        for (int i = 0; i < 5; i++) begin
            wait_ack("t2_ack_seen", 4'b0001 << exp_q[0], NB * BIT + 10);
            check("t2_order", 32'(gnt_id), 32'(exp_q.pop_front()));
            if (prev_cyc >= 0) check("t2_spacing", 32'(cyc - prev_cyc), 32'(NB * BIT + 1));
            prev_cyc = cyc;
            if (i == 4) req = 4'b0000;
            @(negedge clk);
        end
        for (int n = 0; n < NB * BIT + 10 && busy; n++) @(negedge clk);
        check("t2_idle", 32'(busy), 32'd0);

        // Requester 2 pulses while busy and withdraws: no grant.
        data = 32'h0000_005A;
        req  = 4'b0001;
        wait_ack("t3_ack0", 4'b0001, 4);
        req = 4'b0000;
        repeat (100) @(negedge clk);
        req = 4'b0100;
        @(negedge clk);
        req = 4'b0000;
        n_ack = 0;
        for (int n = 0; n < NB * BIT + 50; n++) begin
            if (ack != 4'b0000) n_ack++;
            @(negedge clk);
        end
        check("t3_no_ack", 32'(n_ack), 32'd0);
        check("t3_idle", 32'(busy), 32'd0);

        // Reset 300 clocks into a frame; held request restarts cleanly.
        data = 32'h0000_C300;
        req  = 4'b0010;
        wait_ack("t4_ack", 4'b0010, 4);
        repeat (300) @(negedge clk);
        check("t4_pre_tx", 32'(tx), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("t4_async_tx", 32'(tx), 32'd1);
        check("t4_async_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t4_regrant", 32'(ack), 32'(4'b0010));
        req = 4'b0000;
        capture(8'h00, 1'b0, bits, blen);
`ifdef PARITY_EN
        check("t4_frame", 32'(bits), 32'h586);
`else
        check("t4_frame", 32'(bits), 32'h386);
`endif

        // Byte is latched on ack; later data changes are ignored.
        data = 32'h0000_3C00;
        req  = 4'b0010;
        wait_ack("t5_ack", 4'b0010, 4);
        req = 4'b0000;
        capture(8'hFF, 1'b1, bits, blen);
`ifdef PARITY_EN
        check("t5_frame", 32'(bits), 32'h478);
`else
        check("t5_frame", 32'(bits), 32'h278);
`endif

        // Odd / even popcount bytes.
        data = 32'h0000_0007;
        req  = 4'b0001;
        wait_ack("t6_ack07", 4'b0001, 4);
        req = 4'b0000;
        capture(8'h00, 1'b0, bits, blen);
`ifdef PARITY_EN
        check("t6_frame07", 32'(bits), 32'h60E);
        check("t6_len07", 32'(blen), 32'd704);
`else
        check("t6_frame07", 32'(bits), 32'h20E);
        check("t6_len07", 32'(blen), 32'd640);
`endif
        data = 32'h0000_0003;
        req  = 4'b0001;
        wait_ack("t6_ack03", 4'b0001, 4);
        req = 4'b0000;
        capture(8'h00, 1'b0, bits, blen);
`ifdef PARITY_EN
        check("t6_frame03", 32'(bits), 32'h406);
`else
        check("t6_frame03", 32'(bits), 32'h206);
`endif
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
